noc_host_bridge: RTL

- Parametrised host-to-NoC bridge for the binary-tree message NoC, N host ports.
- Each host gets an injection FIFO feeding its leaf ingress port and an ejection FIFO fed from its leaf egress port.
- Ejection grant is credit-based, so the NoC is back-pressured when a host stops draining. The NoC egress grant is no longer tied high.
- Destinations are range-checked. Out-of-range packets are discarded and counted per host.

---
 rtl/noc_host_bridge.sv | 114 +++++++++++
 1 files changed

// File: rtl/noc_host_bridge.sv
// Host-to-NoC bridge: per-host injection FIFO toward the leaf ingress port and
// credit-gated ejection FIFO from the leaf egress port, with destination range checking.
module noc_host_bridge #(
  parameter int N         = 4,
  parameter int D_W       = 38,
  parameter int A_W       = $clog2(N) + 1,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int ERR_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              host_req,
  output logic [N-1:0]              host_gnt,
  input  logic [N-1:0][D_W-1:0]     host_data,
  input  logic [N-1:0][A_W-1:0]     host_dest,
  output logic [N-1:0]              host_rx_valid,
  input  logic [N-1:0]              host_rx_ready,
  output logic [N-1:0][D_W-1:0]     host_rx_data,
  output logic [N-1:0]              noc_rx_valid,
  input  logic [N-1:0]              noc_rx_gnt,
  output logic [N-1:0][D_W-1:0]     noc_rx_data,
  output logic [N-1:0][A_W-1:0]     noc_rx_addr,
  input  logic [N-1:0]              noc_tx_valid,
  output logic [N-1:0]              noc_tx_gnt,
  input  logic [N-1:0][D_W-1:0]     noc_tx_data,
  output logic [N-1:0][ERR_W-1:0]   drop_cnt
);

  localparam int IP_W = $clog2(INJ_DEPTH);
  localparam int EP_W = $clog2(EJ_DEPTH);
  localparam int IE_W = A_W + D_W;
  localparam logic [A_W-1:0]  DEST_LIM = A_W'(N);
  localparam logic [EP_W:0]   EJ_LIM   = (EP_W + 1)'(EJ_DEPTH);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_host
    logic [IP_W:0]      inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
    logic [IE_W-1:0]    inj_mem_q [INJ_DEPTH];
    logic               inj_full, inj_empty, inj_accept, inj_legal, inj_push, inj_pop;
    logic [ERR_W-1:0]   drop_q, drop_d;

    logic [EP_W:0]      ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d, ej_cnt_d;
    logic [D_W-1:0]     ej_mem_q [EJ_DEPTH];
    logic               ej_empty, ej_push, ej_pop, ej_gnt_q, ej_gnt_d;

    // Injection: host side write, leaf ingress reads the head (fall-through).
    assign inj_full   = (inj_wr_q[IP_W-1:0] == inj_rd_q[IP_W-1:0]) &&
                        (inj_wr_q[IP_W] != inj_rd_q[IP_W]);
    assign inj_empty  = (inj_wr_q == inj_rd_q);
    assign inj_accept = host_req[i] & ~inj_full;
    assign inj_legal  = (host_dest[i] < DEST_LIM);
    assign inj_push   = inj_accept & inj_legal;
    assign inj_pop    = ~inj_empty & noc_rx_gnt[i];
    assign inj_wr_d   = inj_wr_q + (IP_W + 1)'(inj_push);
    assign inj_rd_d   = inj_rd_q + (IP_W + 1)'(inj_pop);
    assign drop_d     = (inj_accept && !inj_legal) ? sat_inc(drop_q) : drop_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        inj_wr_q <= '0;
        inj_rd_q <= '0;
        drop_q   <= '0;
      end else begin
        inj_wr_q <= inj_wr_d;
        inj_rd_q <= inj_rd_d;
        drop_q   <= drop_d;
      end
    end

    always_ff @(posedge clk) begin
      if (inj_push) inj_mem_q[inj_wr_q[IP_W-1:0]] <= {host_dest[i], host_data[i]};
    end

    assign host_gnt[i]     = ~inj_full;
    assign noc_rx_valid[i] = ~inj_empty;
    assign noc_rx_addr[i]  = inj_mem_q[inj_rd_q[IP_W-1:0]][IE_W-1:D_W];
    assign noc_rx_data[i]  = inj_mem_q[inj_rd_q[IP_W-1:0]][D_W-1:0];
    assign drop_cnt[i]     = drop_q;

    // Ejection: the egress credit is the registered "room left" of the next occupancy.
    assign ej_empty = (ej_wr_q == ej_rd_q);
    assign ej_push  = noc_tx_valid[i] & ej_gnt_q;
    assign ej_pop   = ~ej_empty & host_rx_ready[i];
    assign ej_wr_d  = ej_wr_q + (EP_W + 1)'(ej_push);
    assign ej_rd_d  = ej_rd_q + (EP_W + 1)'(ej_pop);
    assign ej_cnt_d = ej_wr_d - ej_rd_d;
    assign ej_gnt_d = (ej_cnt_d < EJ_LIM);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ej_wr_q  <= '0;
        ej_rd_q  <= '0;
        ej_gnt_q <= 1'b1;
      end else begin
        ej_wr_q  <= ej_wr_d;
        ej_rd_q  <= ej_rd_d;
        ej_gnt_q <= ej_gnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (ej_push) ej_mem_q[ej_wr_q[EP_W-1:0]] <= noc_tx_data[i];
    end

    assign noc_tx_gnt[i]    = ej_gnt_q;
    assign host_rx_valid[i] = ~ej_empty;
    assign host_rx_data[i]  = ej_mem_q[ej_rd_q[EP_W-1:0]];
  end

endmodule
